// File: rtl/twiddle_pkg.sv
// Shared types and constants for the FFT twiddle ROM read sequencer.
// ROM layout: addr[5:4] selects the bank, addr[3:0] is the index k.
package twiddle_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;
   localparam int K_W    = 4;
   localparam int REP_W  = 8;

   localparam logic [1:0] BANK_W32   = 2'b00;
   localparam logic [1:0] BANK_W16   = 2'b01;
   localparam logic [1:0] BANK_W48   = 2'b10;
   localparam logic [1:0] BANK_UNITY = 2'b11;

   localparam logic [K_W-1:0] TW_INDEX_MAX = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F1,
      S_F2,
      S_F3,
      S_CAP,
      S_OUT,
      S_DONE
   } state_e;

   // Bypass forces every fetch onto the unity bank.
   function automatic logic [1:0] fetch_bank(
      input logic       byp,
      input logic [1:0] bank
   );
      return byp ? BANK_UNITY : bank;
   endfunction

endpackage

// File: rtl/twiddle_seq_ctl.sv
// Fetch FSM with k and repeat counters; drives the ROM address and capture strobes.
// Ports: start/abort/bypass/cfg_repeat_i, tw_ready_i in; rom_addr_o, cap*_o, k/valid/last/busy/done out.
module twiddle_seq_ctl
   import twiddle_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              bypass_i,
   input  logic [REP_W-1:0]  cfg_repeat_i,
   input  logic              tw_ready_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              cap1_o,
   output logic              cap2_o,
   output logic              load_o,
   output logic [K_W-1:0]    k_o,
   output logic              valid_o,
   output logic              last_o,
   output logic              busy_o,
   output logic              done_o
);

   state_e              state_q, state_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [REP_W-1:0]    rep_q, rep_d;
   logic [REP_W-1:0]    cfg_q, cfg_d;
   logic                byp_q, byp_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                fire;

   assign fire = (state_q == S_OUT) && tw_ready_i;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      rep_d   = rep_q;
      cfg_d   = cfg_q;
      byp_d   = byp_q;
      addr_d  = addr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_F1;
               byp_d   = bypass_i;
               cfg_d   = cfg_repeat_i;
               k_d     = '0;
               addr_d  = {fetch_bank(bypass_i, BANK_W16), 4'd0};
            end
         end
         S_F1: begin
            state_d = S_F2;
            addr_d  = {fetch_bank(byp_q, BANK_W32), k_q};
         end
         S_F2: begin
            state_d = S_F3;
            addr_d  = {fetch_bank(byp_q, BANK_W48), k_q};
         end
         S_F3: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            state_d = S_OUT;
            rep_d   = (cfg_q == '0) ? 8'd1 : cfg_q;
         end
         S_OUT: begin
            if (fire) begin
               if (rep_q == 8'd1) begin
                  if (k_q == TW_INDEX_MAX) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_F1;
                     k_d     = k_q + 4'd1;
                     addr_d  = {fetch_bank(byp_q, BANK_W16), k_q + 4'd1};
                  end
               end else begin
                  rep_d = rep_q - 8'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Abort wins over everything; the address simply holds.
      if (abort_i) begin
         state_d = S_IDLE;
         addr_d  = addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         rep_q   <= '0;
         cfg_q   <= '0;
         byp_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         rep_q   <= rep_d;
         cfg_q   <= cfg_d;
         byp_q   <= byp_d;
         addr_q  <= addr_d;
      end
   end

   // ROM data lags the address by one cycle, so each strobe
   // captures the word addressed in the previous state.
   assign cap1_o     = (state_q == S_F2) && !abort_i;
   assign cap2_o     = (state_q == S_F3) && !abort_i;
   assign load_o     = (state_q == S_CAP) && !abort_i;
   assign rom_addr_o = addr_q;
   assign k_o        = k_q;
   assign valid_o    = (state_q == S_OUT);
   assign last_o     = (state_q == S_OUT) && (k_q == TW_INDEX_MAX)
                       && (rep_q == 8'd1);
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_DONE);

endmodule

// File: rtl/twiddle_seq.sv
// Read-side twiddle ROM sequencer: fetches W^16k, W^32k, W^48k and presents them as a triplet.
// Ports: start/abort/bypass/cfg_repeat control, rom_addr/rom_data*, tw_* valid/ready output, busy/done.
module twiddle_seq
   import twiddle_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  bypass,
   input  logic [7:0]            cfg_repeat,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_datar,
   input  logic [DATA_WIDTH-1:0] rom_datai,
   output logic                  tw_valid,
   input  logic                  tw_ready,
   output logic [DATA_WIDTH-1:0] tw1r,
   output logic [DATA_WIDTH-1:0] tw1i,
   output logic [DATA_WIDTH-1:0] tw2r,
   output logic [DATA_WIDTH-1:0] tw2i,
   output logic [DATA_WIDTH-1:0] tw3r,
   output logic [DATA_WIDTH-1:0] tw3i,
   output logic [3:0]            tw_k,
   output logic                  tw_last,
   output logic                  busy,
   output logic                  done
);

   logic cap1, cap2, load;

   logic [DATA_WIDTH-1:0] s1r_q, s1i_q, s2r_q, s2i_q;
   logic [DATA_WIDTH-1:0] o1r_q, o1i_q, o2r_q, o2i_q;
   logic [DATA_WIDTH-1:0] o3r_q, o3i_q;

   twiddle_seq_ctl u_ctl (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .bypass_i     (bypass),
      .cfg_repeat_i (cfg_repeat),
      .tw_ready_i   (tw_ready),
      .rom_addr_o   (rom_addr),
      .cap1_o       (cap1),
      .cap2_o       (cap2),
      .load_o       (load),
      .k_o          (tw_k),
      .valid_o      (tw_valid),
      .last_o       (tw_last),
      .busy_o       (busy),
      .done_o       (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1r_q <= '0;
         s1i_q <= '0;
         s2r_q <= '0;
         s2i_q <= '0;
         o1r_q <= '0;
         o1i_q <= '0;
         o2r_q <= '0;
         o2i_q <= '0;
         o3r_q <= '0;
         o3i_q <= '0;
      end else begin
         if (cap1) begin
            s1r_q <= rom_datar;
            s1i_q <= rom_datai;
         end
         if (cap2) begin
            s2r_q <= rom_datar;
            s2i_q <= rom_datai;
         end
         // Third word goes straight to the output bank.
         if (load) begin
            o1r_q <= s1r_q;
            o1i_q <= s1i_q;
            o2r_q <= s2r_q;
            o2i_q <= s2i_q;
            o3r_q <= rom_datar;
            o3i_q <= rom_datai;
         end
      end
   end

   assign tw1r = o1r_q;
   assign tw1i = o1i_q;
   assign tw2r = o2r_q;
   assign tw2i = o2i_q;
   assign tw3r = o3r_q;
   assign tw3i = o3i_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq with a registered 64-entry ROM model.
// Covers latency, repeats with stalls, bypass, abort, async reset and start-while-busy.
module tb_twiddle_seq;

   typedef struct packed {
      logic [3:0]  k;
      logic        last;
      logic [15:0] r1, i1, r2, i2, r3, i3;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, bypass;
   logic [7:0]  cfg_repeat;
   logic [5:0]  rom_addr;
   logic [15:0] rom_datar, rom_datai;
   logic        tw_valid, tw_ready;
   logic [15:0] tw1r, tw1i, tw2r, tw2i, tw3r, tw3i;
   logic [3:0]  tw_k;
   logic        tw_last, busy, done;

   logic [15:0] rom_r [64];
   logic [15:0] rom_i [64];

   beat_t q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    rdy_mode = 0;
   bit    chk_byp = 1'b0;
   bit    last_acc = 1'b0;

   always #5 clk = ~clk;

   twiddle_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .bypass     (bypass),
      .cfg_repeat (cfg_repeat),
      .rom_addr   (rom_addr),
      .rom_datar  (rom_datar),
      .rom_datai  (rom_datai),
      .tw_valid   (tw_valid),
      .tw_ready   (tw_ready),
      .tw1r       (tw1r),
      .tw1i       (tw1i),
      .tw2r       (tw2r),
      .tw2i       (tw2i),
      .tw3r       (tw3r),
      .tw3i       (tw3i),
      .tw_k       (tw_k),
      .tw_last    (tw_last),
      .busy       (busy),
      .done       (done)
   );

   // ROM: data appears one cycle after the address.
   always @(posedge clk) begin
      rom_datar <= rom_r[rom_addr];
      rom_datai <= rom_i[rom_addr];
   end

   function automatic logic [15:0] wq(input int n, input bit im);
      real a, x;
      a = 2.0 * 3.14159265358979 * n / 1024.0;
      x = im ? -32767.0 * $sin(a) : 32767.0 * $cos(a);
      x = (x >= 0.0) ? x + 0.5 : x - 0.5;
      return 16'($rtoi(x));
   endfunction

   function automatic beat_t exp_beat(input int k, input bit byp, input bit last);
      beat_t b;
      b.k    = 4'(k);
      b.last = last;
      if (byp || k == 0)
         {b.r1, b.i1, b.r2, b.i2, b.r3, b.i3} =
            {16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0};
      else if (k == 1)
         {b.r1, b.i1, b.r2, b.i2, b.r3, b.i3} =
            {16'h7F61, 16'hF374, 16'h7D89, 16'hE707, 16'h7A7C, 16'hDAD8};
      else if (k == 15)
         {b.r1, b.i1, b.r2, b.i2, b.r3, b.i3} =
            {16'h0C8C, 16'h809F, 16'h8277, 16'hE707, 16'hDAD8, 16'h7A7C};
      else begin
         b.r1 = wq(16 * k, 1'b0);
         b.i1 = wq(16 * k, 1'b1);
         b.r2 = wq(32 * k, 1'b0);
         b.i2 = wq(32 * k, 1'b1);
         b.r3 = wq(48 * k, 1'b0);
         b.i3 = wq(48 * k, 1'b1);
      end
      return b;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ready pattern: 0 = always ready, 1 = toggling, 2 = held by the driver.
   initial begin
      tw_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)
            tw_ready = 1'b1;
         else if (rdy_mode == 1)
            tw_ready = ~tw_ready;
      end
   end

   // Monitor: compares every presented beat against the queue head.
   initial begin
      beat_t act;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_acc = 1'b0;
         end else begin
            if (done || last_acc)
               chk("done_pulse", 128'(done), 128'(last_acc));
            last_acc = 1'b0;
            if (chk_byp && busy)
               chk("bypass_bank", 128'(rom_addr[5:4]), 128'(2'b11));
            if (tw_valid) begin
               act = {tw_k, tw_last, tw1r, tw1i, tw2r, tw2i, tw3r, tw3i};
               if (q.size() == 0) begin
                  chk("unexpected_beat", 128'(act), 128'(0));
               end else begin
                  chk($sformatf("beat_k%0d", q[0].k), 128'(act), 128'(q[0]));
                  if (tw_ready) begin
                     last_acc = q[0].last;
                     void'(q.pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic run_seq(input int rep, input bit byp, input int mode,
                          input bit poke);
      int n, lat, cyc;
      n = (rep == 0) ? 1 : rep;
      for (int k = 0; k < 16; k++)
         for (int r = 0; r < n; r++)
            q.push_back(exp_beat(k, byp, (k == 15) && (r == n - 1)));
      rdy_mode = mode;
      chk_byp  = byp;
      @(posedge clk);
      #1;
      start      = 1'b1;
      bypass     = byp;
      cfg_repeat = 8'(rep);
      @(posedge clk);
      #1;
      start  = 1'b0;
      bypass = 1'b0;
      lat = 0;
      while (!tw_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("first_beat_latency", 128'(lat + 1), 128'(5));
      cyc = 0;
      while (q.size() != 0 && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (poke)
            start = tw_valid && (tw_k == 4'd3);
      end
      chk("beats_drained", 128'(q.size()), 128'(0));
      chk("done_after_last", 128'(done), 128'(1));
      start = poke;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("idle_after_done", 128'({busy, tw_valid}), 128'(0));
      @(posedge clk);
      #1;
      chk("still_idle", 128'({busy, tw_valid}), 128'(0));
      chk_byp  = 1'b0;
      rdy_mode = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int a = 0; a < 64; a++) begin
         int k, n;
         k = a % 16;
         case (a / 16)
            0: n = 32 * k;
            1: n = 16 * k;
            2: n = 48 * k;
            default: n = 0;
         endcase
         rom_r[a] = wq(n, 1'b0);
         rom_i[a] = wq(n, 1'b1);
      end
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      bypass     = 1'b0;
      cfg_repeat = 8'd0;
      #3;
      chk("reset_ctrl", 128'({busy, done, tw_valid, tw_last, tw_k, rom_addr}),
          128'(0));
      chk("reset_data", 128'({tw1r, tw1i, tw2r, tw2i, tw3r, tw3i}), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_seq(1, 1'b0, 0, 1'b0);

      // Async reset landing in F2.
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("in_f2_busy", 128'(busy), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl",
          128'({busy, done, tw_valid, tw_last, tw_k, rom_addr}), 128'(0));
      chk("midrst_data", 128'({tw1r, tw1i, tw2r, tw2i, tw3r, tw3i}), 128'(0));
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("no_beat_after_reset", 128'({busy, tw_valid}), 128'(0));

      run_seq(3, 1'b0, 1, 1'b0);
      run_seq(0, 1'b1, 0, 1'b0);

      // Abort while k = 7 is on the output.
      for (int k = 0; k < 16; k++)
         q.push_back(exp_beat(k, 1'b0, k == 15));
      @(posedge clk);
      #1;
      start      = 1'b1;
      cfg_repeat = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (!(tw_valid && tw_k == 4'd7) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("reached_k7", 128'({tw_valid, tw_k}), 128'({1'b1, 4'd7}));
      rdy_mode = 2;
      tw_ready = 1'b0;
      abort    = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_idle", 128'({busy, tw_valid, done}), 128'(0));
      chk("abort_left", 128'(q.size()), 128'(9));
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("abort_quiet", 128'({busy, tw_valid}), 128'(0));
      rdy_mode = 0;

      run_seq(1, 1'b0, 0, 1'b1);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Read-side sequencer for the 64-entry, 16-bit twiddle ROM of the 1024-point WISHBONE FFT.
- ROM banks, selected by address[5:4]: bank0 = W^(32k), bank1 = W^(16k), bank2 = W^(48k), bank3 = unity; k = address[3:0].
- For each k = 0..15 the block fetches one radix-4 twiddle triplet (W^16k, W^32k, W^48k) and presents it to the butterfly datapath through a valid/ready handshake.
- Each triplet is repeated a programmable number of times.

Parameters:
- DATA_WIDTH, 16, twiddle component width (two's complement, Q1.15).
- ADDR_WIDTH, 6, ROM address width; fixed layout is 2 bank bits plus 4 index bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- bypass  in  1  latched at start; all fetches use bank3 (unity).
- cfg_repeat  in  8  beats per triplet, latched at start; 0 is treated as 1.
- rom_addr  out  6  ROM address.
- rom_datar  in  16  ROM real data, valid 1 cycle after rom_addr.
- rom_datai  in  16  ROM imaginary data, valid 1 cycle after rom_addr.
- tw_valid  out  1  triplet valid.
- tw_ready  in  1  consumer ready.
- tw1r, tw1i, tw2r, tw2i, tw3r, tw3i  out  16 each  triplet W^16k, W^32k, W^48k.
- tw_k  out  4  current index k.
- tw_last  out  1  final beat of the sequence (k = 15, last repeat).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: state IDLE. rom_addr = 0, all tw* = 0, tw_k = 0, tw_valid = 0, tw_last = 0, busy = 0, done = 0, repeat counter = 0.
- States and transitions:
  - IDLE -> F1 on start. Latch bypass and cfg_repeat; set k = 0.
  - F1: rom_addr = {01,k} (or {11,k} if bypass) -> F2.
  - F2: rom_addr = {00,k} (or {11,k}); capture the data for F1 into tw1 staging -> F3.
  - F3: rom_addr = {10,k} (or {11,k}); capture tw2 staging -> CAP.
  - CAP: capture tw3; load all three into the output registers; load rep = max(cfg_repeat, 1); tw_valid = 1 -> OUT.
  - OUT: on each tw_valid && tw_ready, rep decrements. When rep reaches 1 and a beat is accepted: if k = 15 -> DONE, else k+1 -> F1 with tw_valid = 0.
  - DONE: done = 1 for one cycle -> IDLE.
- Latency: start in cycle 0 gives tw_valid in cycle 5. Between k groups there are 4 bubble cycles (no prefetch).
- tw_valid must not depend combinationally on tw_ready. While tw_valid = 1 and tw_ready = 0, all tw*, tw_k and tw_last hold stable.
- tw_last = 1 only in OUT with k = 15 and rep = 1.
- rom_addr holds its last value outside F1–F3.
- Total beats per sequence = 16 × max(cfg_repeat, 1).
- start while busy is ignored, including the DONE cycle.
- abort has priority over every transition: next state IDLE, tw_valid = 0, no done pulse. Output data registers keep their values.
- Asynchronous reset mid-sequence forces reset values immediately. No beat is generated after reset deasserts until a new start.
- The k counter wraps only through DONE; there is no 15->0 wrap inside a sequence.

Decomposition:
- Shared package twiddle_pkg:
  - bank codes BANK_W32 = 2'b00, BANK_W16 = 2'b01, BANK_W48 = 2'b10, BANK_UNITY = 2'b11;
  - TW_INDEX_MAX = 15;
  - state enum and width constants.
- One sub-module, twiddle_seq_ctl: the FSM plus k and rep counters, producing rom_addr and capture strobes.
- The top level holds the staging and output registers and instantiates rom3 only in the testbench.

Test Plan:
- start with cfg_repeat = 1, tw_ready = 1 -> first beat k = 0 arrives 5 cycles after start, all triplets 7FFF/0000; 16 beats total; tw_last on k = 15; done 1 cycle after the last beat.
- Same run, inspect k = 1 -> tw1 = 7F61/F374, tw2 = 7D89/E707, tw3 = 7A7C/DAD8. Inspect k = 15 -> tw1 = 0C8C/809F, tw2 = 8277/E707, tw3 = DAD8/7A7C.
- cfg_repeat = 3, tw_ready toggling 1010… -> each triplet is accepted exactly 3 times with outputs stable during stalls; 48 beats total.
- bypass = 1, cfg_repeat = 0 -> 16 beats, every tw* = 7FFF/0000, rom_addr[5:4] = 11 throughout.
- abort asserted during OUT at k = 7 -> tw_valid low next cycle, busy low, no done. A following start restarts at k = 0.
- rst_n pulsed low during F2 -> outputs at reset values immediately. start asserted while busy -> ignored (k does not restart).
